// File: rtl/fabric_verif_pkg.sv
// fabric_verif_pkg: shared FSM state encodings and bit-vector helpers for the response checker.
package fabric_verif_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SKIP = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;
  function automatic logic [5:0] popcount(input logic [31:0] v);
    popcount = '0;
    for (int i = 0; i < 32; i++) popcount = popcount + 6'(v[i]);
  endfunction
  function automatic logic [4:0] lowest_set_bit(input logic [31:0] v);
    lowest_set_bit = '0;
    for (int i = 31; i >= 0; i--) if (v[i]) lowest_set_bit = 5'(i);
  endfunction
endpackage

// File: rtl/fabric_response_checker_if.sv
// fabric_response_checker_if: stimulus/compare bus between the run controller and the checker.
interface fabric_response_checker_if #(
  parameter int NUM_OUT = 2,
  parameter int ERR_W   = 16,
  parameter int CYC_W   = 16
);
  localparam int IDX_W = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  logic               start;
  logic               sample_en;
  logic [NUM_OUT-1:0] gfpga_out;
  logic [NUM_OUT-1:0] bench_out;
  logic [NUM_OUT-1:0] bench_valid;
  logic [NUM_OUT-1:0] mismatch_flag;
  logic [ERR_W-1:0]   err_count;
  logic               busy;
  logic               done;
  logic               pass;
  logic [IDX_W-1:0]   first_err_idx;
  logic [CYC_W-1:0]   first_err_cycle;
  modport master (
    output start, sample_en, gfpga_out, bench_out, bench_valid,
    input  mismatch_flag, err_count, busy, done, pass, first_err_idx, first_err_cycle
  );
  modport slave (
    input  start, sample_en, gfpga_out, bench_out, bench_valid,
    output mismatch_flag, err_count, busy, done, pass, first_err_idx, first_err_cycle
  );
endinterface

// File: rtl/fabric_mismatch_detect.sv
// fabric_mismatch_detect: masked compare plus rising-edge count and lowest rising index.
module fabric_mismatch_detect
  import fabric_verif_pkg::*;
#(
  parameter int NUM_OUT = 2,
  parameter int IDX_W   = 1,
  parameter int CNT_W   = 2
) (
  input  logic [NUM_OUT-1:0] gfpga,
  input  logic [NUM_OUT-1:0] bench,
  input  logic [NUM_OUT-1:0] valid,
  input  logic [NUM_OUT-1:0] flag,
  output logic [NUM_OUT-1:0] mism,
  output logic [CNT_W-1:0]   rise_cnt,
  output logic [IDX_W-1:0]   low_idx,
  output logic               any_rise
);
  logic [NUM_OUT-1:0] rise;
  assign mism     = valid & (gfpga ^ bench);
  assign rise     = mism & ~flag;
  assign any_rise = |rise;
  assign rise_cnt = CNT_W'(popcount(32'(rise)));
  assign low_idx  = IDX_W'(lowest_set_bit(32'(rise)));
endmodule

// File: rtl/fabric_response_checker.sv
// fabric_response_checker: compares fabric vs reference outputs over a fixed run and reports errors.
module fabric_response_checker
  import fabric_verif_pkg::*;
#(
  parameter int NUM_OUT      = 2,
  parameter int ERR_W        = 16,
  parameter int CYC_W        = 16,
  parameter int SKIP_SAMPLES = 1,
  parameter int RUN_SAMPLES  = 10
) (
  input logic clk,
  input logic reset,
  fabric_response_checker_if.slave bus
);
  localparam int IDX_W     = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  localparam int CNT_W     = $clog2(NUM_OUT + 1);
  localparam int SKIP_W    = SKIP_SAMPLES > 1 ? $clog2(SKIP_SAMPLES) : 1;
  localparam int SKIP_LAST = SKIP_SAMPLES > 0 ? SKIP_SAMPLES - 1 : 0;
  state_t             state;
  logic [NUM_OUT-1:0] flag, mism;
  logic [ERR_W-1:0]   err;
  logic [ERR_W:0]     sum;
  logic [IDX_W-1:0]   fidx, low_idx;
  logic [CYC_W-1:0]   fcyc, cyc;
  logic [SKIP_W-1:0]  skp;
  logic [CNT_W-1:0]   rise_cnt;
  logic               any_rise, idle;
  fabric_mismatch_detect #(.NUM_OUT(NUM_OUT), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_det (
    .gfpga(bus.gfpga_out), .bench(bus.bench_out), .valid(bus.bench_valid), .flag(flag),
    .mism(mism), .rise_cnt(rise_cnt), .low_idx(low_idx), .any_rise(any_rise)
  );
  assign idle = state == ST_IDLE || state == ST_DONE;
  // One spare bit catches the carry so the counter saturates instead of wrapping.
  assign sum  = {1'b0, err} + (ERR_W + 1)'(rise_cnt);
  always_ff @(posedge clk) begin
    if (reset || (idle && bus.start)) begin
      state <= reset ? ST_IDLE : (SKIP_SAMPLES == 0 ? ST_RUN : ST_SKIP);
      flag  <= '0;
      err   <= '0;
      fidx  <= '0;
      fcyc  <= '0;
      cyc   <= '0;
      skp   <= '0;
    end else if (bus.sample_en && state == ST_SKIP) begin
      skp <= skp + 1'b1;
      if (skp == SKIP_W'(SKIP_LAST)) state <= ST_RUN;
    end else if (bus.sample_en && state == ST_RUN) begin
      flag <= mism;
      err  <= sum[ERR_W] ? '1 : sum[ERR_W-1:0];
      // err_count only leaves zero on a rising edge, so zero marks "no error event yet".
      if (err == '0 && any_rise) begin
        fidx <= low_idx;
        fcyc <= cyc;
      end
      cyc <= cyc + 1'b1;
      if (cyc == CYC_W'(RUN_SAMPLES - 1)) state <= ST_DONE;
    end
  end
  assign bus.mismatch_flag   = flag;
  assign bus.err_count       = err;
  assign bus.busy            = state == ST_SKIP || state == ST_RUN;
  assign bus.done            = state == ST_DONE;
  assign bus.pass            = state == ST_DONE && err == '0;
  assign bus.first_err_idx   = fidx;
  assign bus.first_err_cycle = fcyc;
endmodule

// File: tb/tb_fabric_response_checker.sv
// tb_fabric_response_checker: directed vector bench for the response checker (plus a 2-bit counter copy).
module tb_fabric_response_checker;
  typedef struct {
    logic [1:0]  g, b, v, flag;
    logic [15:0] err;
    logic        busy, done;
  } vec_t;
  logic clk = 0, reset = 1;
  int tests = 0, fails = 0;
  vec_t tv[11];
  fabric_response_checker_if #(.NUM_OUT(2), .ERR_W(16), .CYC_W(16)) b1 ();
  fabric_response_checker_if #(.NUM_OUT(2), .ERR_W(2), .CYC_W(16)) b2 ();
  fabric_response_checker #(.NUM_OUT(2), .ERR_W(16), .CYC_W(16), .SKIP_SAMPLES(1), .RUN_SAMPLES(10))
    dut (.clk(clk), .reset(reset), .bus(b1));
  fabric_response_checker #(.NUM_OUT(2), .ERR_W(2), .CYC_W(16), .SKIP_SAMPLES(1), .RUN_SAMPLES(10))
    dut_sat (.clk(clk), .reset(reset), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic st, input logic en, input logic [1:0] g, input logic [1:0] b, input logic [1:0] v);
    b1.start = st; b1.sample_en = en; b1.gfpga_out = g; b1.bench_out = b; b1.bench_valid = v;
    b2.start = st; b2.sample_en = en; b2.gfpga_out = g; b2.bench_out = b; b2.bench_valid = v;
    @(posedge clk);
    #1;
    b1.start = 0; b1.sample_en = 0;
    b2.start = 0; b2.sample_en = 0;
  endtask
  task automatic chk_all(input string name, input logic [1:0] flag, input logic [15:0] err,
                         input logic busy, input logic done, input logic pass);
    chk({name, ".flag"}, 32'(b1.mismatch_flag), 32'(flag));
    chk({name, ".err"},  32'(b1.err_count), 32'(err));
    chk({name, ".busy"}, 32'(b1.busy), 32'(busy));
    chk({name, ".done"}, 32'(b1.done), 32'(done));
    chk({name, ".pass"}, 32'(b1.pass), 32'(pass));
  endtask
  task automatic clean_run(input string name);
    drive(1, 0, 2'b01, 2'b01, 2'b11);
    chk({name, ".started"}, 32'(b1.busy), 1);
    for (int i = 0; i < 11; i++) drive(0, 1, 2'b01, 2'b01, 2'b11);
    chk_all(name, 2'b00, 16'd0, 0, 1, 1);
  endtask
  initial begin
    tv[0]  = '{2'b10, 2'b01, 2'b11, 2'b00, 16'd0, 1'b1, 1'b0};
    tv[1]  = '{2'b01, 2'b01, 2'b11, 2'b00, 16'd0, 1'b1, 1'b0};
    tv[2]  = '{2'b01, 2'b01, 2'b11, 2'b00, 16'd0, 1'b1, 1'b0};
    tv[3]  = '{2'b11, 2'b01, 2'b11, 2'b10, 16'd1, 1'b1, 1'b0};
    tv[4]  = '{2'b11, 2'b01, 2'b11, 2'b10, 16'd1, 1'b1, 1'b0};
    tv[5]  = '{2'b11, 2'b01, 2'b11, 2'b10, 16'd1, 1'b1, 1'b0};
    tv[6]  = '{2'b01, 2'b01, 2'b11, 2'b00, 16'd1, 1'b1, 1'b0};
    tv[7]  = '{2'b10, 2'b01, 2'b11, 2'b11, 16'd3, 1'b1, 1'b0};
    tv[8]  = '{2'b01, 2'b01, 2'b11, 2'b00, 16'd3, 1'b1, 1'b0};
    tv[9]  = '{2'b10, 2'b01, 2'b01, 2'b01, 16'd4, 1'b1, 1'b0};
    tv[10] = '{2'b01, 2'b01, 2'b11, 2'b00, 16'd4, 1'b0, 1'b1};
    b1.start = 0; b1.sample_en = 0; b1.gfpga_out = 0; b1.bench_out = 0; b1.bench_valid = 0;
    b2.start = 0; b2.sample_en = 0; b2.gfpga_out = 0; b2.bench_out = 0; b2.bench_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_all("reset", 2'b00, 16'd0, 0, 0, 0);
    chk("reset.fidx", 32'(b1.first_err_idx), 0);
    chk("reset.fcyc", 32'(b1.first_err_cycle), 0);
    clean_run("clean");
    // Table run from DONE: skip-sample mismatch, persistent bit1, both bits, masked bit1.
    drive(1, 0, 2'b01, 2'b01, 2'b11);
    chk_all("restart", 2'b00, 16'd0, 1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      drive(0, 1, tv[i].g, tv[i].b, tv[i].v);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.flag", i), 32'(b1.mismatch_flag), 32'(tv[i].flag));
      chk($sformatf("vec%0d.err", i), 32'(b1.err_count), 32'(tv[i].err));
      chk($sformatf("vec%0d.busy", i), 32'(b1.busy), 32'(tv[i].busy));
      chk($sformatf("vec%0d.done", i), 32'(b1.done), 32'(tv[i].done));
    end
    chk("table.pass", 32'(b1.pass), 0);
    chk("table.fidx", 32'(b1.first_err_idx), 1);
    chk("table.fcyc", 32'(b1.first_err_cycle), 2);
    // Both bits rising on the first compare; start mid-run must be ignored.
    drive(1, 0, 2'b01, 2'b01, 2'b11);
    drive(0, 1, 2'b01, 2'b01, 2'b11);
    drive(0, 1, 2'b10, 2'b01, 2'b11);
    chk_all("both", 2'b11, 16'd2, 1, 0, 0);
    chk("both.fidx", 32'(b1.first_err_idx), 0);
    chk("both.fcyc", 32'(b1.first_err_cycle), 0);
    drive(1, 0, 2'b10, 2'b01, 2'b11);
    chk_all("start_busy", 2'b11, 16'd2, 1, 0, 0);
    for (int i = 1; i < 10; i++) drive(0, 1, 2'b10, 2'b01, 2'b11);
    chk_all("both.end", 2'b11, 16'd2, 0, 1, 0);
    // Toggling double mismatch: 5 rising events of 2 bits; the 2-bit copy must stick at 3.
    drive(1, 0, 2'b01, 2'b01, 2'b11);
    chk("sat.cleared", 32'(b2.err_count), 0);
    drive(0, 1, 2'b01, 2'b01, 2'b11);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, i % 2 == 0 ? 2'b10 : 2'b01, 2'b01, 2'b11);
      if (i == 2) chk("sat.mid", 32'(b2.err_count), 3);
    end
    chk("sat.err", 32'(b2.err_count), 3);
    chk("sat.done", 32'(b2.done), 1);
    chk("sat.wide_err", 32'(b1.err_count), 10);
    // Reset together with start and a strobe on compared sample 4 aborts the run.
    drive(1, 0, 2'b01, 2'b01, 2'b11);
    drive(0, 1, 2'b01, 2'b01, 2'b11);
    drive(0, 1, 2'b00, 2'b01, 2'b11);
    drive(0, 1, 2'b01, 2'b01, 2'b11);
    drive(0, 1, 2'b01, 2'b01, 2'b11);
    chk("pre_reset.err", 32'(b1.err_count), 1);
    reset = 1;
    drive(1, 1, 2'b10, 2'b01, 2'b11);
    reset = 0;
    chk_all("rst_mid", 2'b00, 16'd0, 0, 0, 0);
    chk("rst_mid.fidx", 32'(b1.first_err_idx), 0);
    chk("rst_mid.fcyc", 32'(b1.first_err_cycle), 0);
    drive(0, 1, 2'b10, 2'b01, 2'b11);
    chk_all("rst_after", 2'b00, 16'd0, 0, 0, 0);
    clean_run("fresh");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
